// File: rtl/jt12_split_pkg.sv
// Shared definitions for the jt12 splitter: FSM states, gain format constants
// and the gain-ramp step helper (used when JT12_SPLIT_RAMP_EN is defined).
package jt12_split_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CH0  = 3'd1,
        CH1  = 3'd2,
        CH2  = 3'd3,
        CH3  = 3'd4
    } state_t;

    localparam logic [7:0] GAIN_UNITY     = 8'h10;
    localparam int         GAIN_FRAC_BITS = 4;
    localparam int         NUM_OUT        = 4;

    // Move an effective gain one LSB toward its target, holding once equal.
    function automatic logic [7:0] gain_step(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt)
            return cur + 8'd1;
        else if (cur > tgt)
            return cur - 8'd1;
        else
            return cur;
    endfunction

endpackage

// File: rtl/jt12_split_sat.sv
// Combinational gain stage: unsigned 4.4 gain times signed sample, arithmetic
// shift right by the gain fraction bits (floor), then saturate to wout bits.
module jt12_split_sat
    import jt12_split_pkg::*;
#(
    parameter int win  = 20,
    parameter int wout = 16
) (
    input  logic signed [win-1:0]  din,
    input  logic        [7:0]      gain,
    output logic signed [wout-1:0] dout
);

    localparam int PW = win + 9;

    localparam logic signed [PW-1:0] MAXV = {{(PW-wout+1){1'b0}}, {(wout-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(PW-wout+1){1'b1}}, {(wout-1){1'b0}}};

    logic signed [PW-1:0] w_a;
    logic signed [PW-1:0] w_b;
    logic signed [PW-1:0] w_p;
    logic signed [PW-1:0] w_s;

    // Clamp the scaled value into the signed output range.
    function automatic logic signed [wout-1:0] sat(input logic signed [PW-1:0] v);
        if (v > MAXV)
            return MAXV[wout-1:0];
        else if (v < MINV)
            return MINV[wout-1:0];
        else
            return v[wout-1:0];
    endfunction

    // Both operands are widened to the full product width so the multiply is exact.
    always_comb begin
        w_a  = {{(PW-8){1'b0}}, gain};
        w_b  = {{9{din[win-1]}}, din};
        w_p  = w_a * w_b;
        w_s  = w_p >>> GAIN_FRAC_BITS;
        dout = sat(w_s);
    end

endmodule

// File: rtl/jt12_splitter.sv
// jt12_splitter: fans one mixed signed sample out to four gain-scaled,
// saturated outputs using a single time-multiplexed gain/saturate stage.
// Optional feature macro: JT12_SPLIT_RAMP_EN (per-output gain ramping).
module jt12_splitter
    import jt12_split_pkg::*;
#(
    parameter int win  = 20,
    parameter int wout = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cen,
    input  logic signed [win-1:0]  din,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic        [7:0]      gain0,
    input  logic        [7:0]      gain1,
    input  logic        [7:0]      gain2,
    input  logic        [7:0]      gain3,
    output logic signed [wout-1:0] out0,
    output logic signed [wout-1:0] out1,
    output logic signed [wout-1:0] out2,
    output logic signed [wout-1:0] out3,
    output logic                   out_valid
);

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_ready;
    logic                   w_accept;
    logic [1:0]             w_idx;
    logic [7:0]             w_gain_in [NUM_OUT];
    logic [7:0]             w_gain_sel;
    logic signed [wout-1:0] w_sat;

    logic signed [win-1:0]  r_din;
    logic [7:0]             r_gain  [NUM_OUT];
    logic signed [wout-1:0] r_stage [NUM_OUT-1];
    logic signed [wout-1:0] r_out   [NUM_OUT];
    logic                   r_valid;

    assign w_gain_in[0] = gain0;
    assign w_gain_in[1] = gain1;
    assign w_gain_in[2] = gain2;
    assign w_gain_in[3] = gain3;

    assign w_accept   = cen & din_valid & w_ready;
    assign w_gain_sel = r_gain[w_idx];

    assign din_ready = w_ready;
    assign out0      = r_out[0];
    assign out1      = r_out[1];
    assign out2      = r_out[2];
    assign out3      = r_out[3];
    assign out_valid = r_valid;

    jt12_split_sat #(.win(win), .wout(wout)) u_sat (
        .din  (r_din),
        .gain (w_gain_sel),
        .dout (w_sat)
    );

    // FSM state register; advances only on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else if (cen)
            r_state <= w_next;
    end

    // Next state: wait for a sample in IDLE, then walk the four channels.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (din_valid) w_next = CH0;
            CH0:     w_next = CH1;
            CH1:     w_next = CH2;
            CH2:     w_next = CH3;
            CH3:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs: ready flag and which channel's gain feeds the shared stage.
    always_comb begin
        w_ready = 1'b0;
        w_idx   = 2'd0;
        case (r_state)
            IDLE:    w_ready = 1'b1;
            CH0:     w_idx   = 2'd0;
            CH1:     w_idx   = 2'd1;
            CH2:     w_idx   = 2'd2;
            CH3:     w_idx   = 2'd3;
            default: w_ready = 1'b0;
        endcase
    end

    // Sample/gain capture, per-channel staging, and the simultaneous output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_din   <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < NUM_OUT; i++) begin
                r_gain[i] <= '0;
                r_out[i]  <= '0;
            end
            for (int i = 0; i < NUM_OUT-1; i++)
                r_stage[i] <= '0;
        end else if (cen) begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_din <= din;
                for (int i = 0; i < NUM_OUT; i++) begin
`ifdef JT12_SPLIT_RAMP_EN
                    r_gain[i] <= gain_step(r_gain[i], w_gain_in[i]);
`else
                    r_gain[i] <= w_gain_in[i];
`endif
                end
            end
            case (r_state)
                CH0: r_stage[0] <= w_sat;
                CH1: r_stage[1] <= w_sat;
                CH2: r_stage[2] <= w_sat;
                CH3: begin
                    // Last channel goes straight from the stage so all four land together.
                    r_out[0] <= r_stage[0];
                    r_out[1] <= r_stage[1];
                    r_out[2] <= r_stage[2];
                    r_out[3] <= w_sat;
                    r_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jt12_splitter.sv
// Testbench for jt12_splitter (win=20, wout=16). Honours JT12_SPLIT_RAMP_EN.
module tb_jt12_splitter;
    import jt12_split_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cen = 1'b1;
    logic signed [19:0] din = '0;
    logic               din_valid = 1'b0;
    logic               din_ready;
    logic [7:0]         g [4];
    logic signed [15:0] out0, out1, out2, out3;
    logic               out_valid;

    int total = 0;
    int bad   = 0;
    int cen_mode = 0;
    int cyc = 0;

    jt12_splitter #(.win(20), .wout(16)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .gain0(g[0]), .gain1(g[1]), .gain2(g[2]), .gain3(g[3]),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        cen = (cen_mode == 0) ? 1'b1 : ((cyc % 3) != 0);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference scaling: exact product, floor divide by 16, clamp to 16-bit signed.
    function automatic int scale(input int d, input int gn);
        longint p, s;
        p = longint'(gn) * longint'(d);
        if (p >= 0) s = p / 16;
        else        s = -((-p + 15) / 16);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    // Behavioural model: an accepted sample yields its outputs 4 enabled edges later.
    int m_out [4] = '{0, 0, 0, 0};
    int m_pend[4] = '{0, 0, 0, 0};
    int m_eff [4] = '{0, 0, 0, 0};
    int m_vld  = 0;
    int m_left = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_left = 0;
            m_vld  = 0;
            for (int i = 0; i < 4; i++) begin
                m_out[i] = 0;
                m_eff[i] = 0;
            end
        end
        chk("m_out0", out0, m_out[0]);
        chk("m_out1", out1, m_out[1]);
        chk("m_out2", out2, m_out[2]);
        chk("m_out3", out3, m_out[3]);
        chk("m_out_valid", out_valid, m_vld);
        chk("m_din_ready", din_ready, (m_left == 0) ? 1 : 0);
        if (rst_n && cen) begin
            m_vld = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_out = m_pend;
                    m_vld = 1;
                end
            end else if (din_valid) begin
                m_left = 4;
                for (int i = 0; i < 4; i++) begin
`ifdef JT12_SPLIT_RAMP_EN
                    if (m_eff[i] < int'(g[i])) m_eff[i]++;
                    else if (m_eff[i] > int'(g[i])) m_eff[i]--;
                    m_pend[i] = scale(int'(din), m_eff[i]);
`else
                    m_pend[i] = scale(int'(din), int'(g[i]));
`endif
                end
            end
        end
    end

    task automatic wait_accept(output int n);
        bit ok;
        ok = 0;
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (cen) n++;
            if (cen && din_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int n);
        bit ok;
        ok = 0;
        n = 0;
        repeat (60) begin
            @(posedge clk);
            if (cen) n++;
            #1;
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("valid_timeout", 0, 1);
    endtask

    task automatic check_outs(input string nm, input int e0, input int e1, input int e2, input int e3);
        chk({nm, "_o0"}, out0, e0);
        chk({nm, "_o1"}, out1, e1);
        chk({nm, "_o2"}, out2, e2);
        chk({nm, "_o3"}, out3, e3);
    endtask

    task automatic send(input string nm, input int d, input logic [7:0] g0, input logic [7:0] g1,
                        input logic [7:0] g2, input logic [7:0] g3,
                        input int e0, input int e1, input int e2, input int e3);
        int n;
        din = d[19:0];
        g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
        din_valid = 1'b1;
        wait_accept(n);
        din_valid = 1'b0;
        wait_valid(n);
        chk({nm, "_latency"}, n, 4);
        check_outs(nm, e0, e1, e2, e3);
    endtask

    task automatic backpressure(input string nm);
        int n;
        din = 20'sd1000;
        g[0] = 8'h10; g[1] = 8'h20; g[2] = 8'h08; g[3] = 8'h00;
        din_valid = 1'b1;
        wait_accept(n);
        din = 20'sd3000;
        g[0] = 8'h20; g[1] = 8'h10; g[2] = 8'h00; g[3] = 8'hFF;
        wait_valid(n);
        chk({nm, "_lat1"}, n, 4);
        check_outs({nm, "_first"}, 1000, 2000, 500, 0);
        wait_accept(n);
        chk({nm, "_gap"}, n, 1);
        din_valid = 1'b0;
        wait_valid(n);
        chk({nm, "_lat2"}, n, 4);
        check_outs({nm, "_second"}, 6000, 3000, 0, 32767);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        g[0] = 8'h00; g[1] = 8'h00; g[2] = 8'h00; g[3] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_ready", din_ready, 1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

`ifdef JT12_SPLIT_RAMP_EN
        for (int i = 1; i <= 18; i++) begin
            int e;
            e = 100 * ((i < 16) ? i : 16);
            send("ramp", 1600, GAIN_UNITY, GAIN_UNITY, GAIN_UNITY, GAIN_UNITY, e, e, e, e);
        end
`else
        send("basic", 1000, 8'h10, 8'h20, 8'h08, 8'h00, 1000, 2000, 500, 0);
        send("pos_sat", 20000, 8'hFF, GAIN_UNITY, 8'h01, 8'h00, 32767, 20000, 1250, 0);
        send("neg_sat", -20000, 8'hFF, GAIN_UNITY, 8'h01, 8'h00, -32768, -20000, -1250, 0);
        send("floor", -1, 8'h08, GAIN_UNITY, 8'h01, 8'hFF, -1, -1, -1, -16);
        backpressure("bp");
        cen_mode = 1;
        backpressure("bp_gaps");
        send("gaps_basic", 1000, 8'h10, 8'h20, 8'h08, 8'h00, 1000, 2000, 500, 0);
        cen_mode = 0;
        @(posedge clk);
        #1;

        // Reset while the FSM is in CH2: sample discarded, outputs cleared at once.
        din = 20'sd500;
        g[0] = 8'h10; g[1] = 8'h10; g[2] = 8'h10; g[3] = 8'h10;
        din_valid = 1'b1;
        wait_accept(n);
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("midrst", 0, 0, 0, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", din_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("midrst_no_pulse", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send("after_rst", 1000, 8'h10, 8'h20, 8'h08, 8'h00, 1000, 2000, 500, 0);
`endif
        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
